// File: rtl/reaction_ctrl.sv
// Reaction-timer control FSM: debounced start/react keys, idle/delay/timing/display sequencing.
// Define REACTION_FALSE_START_EN to abort a round on a react press during the random delay.
module reaction_ctrl #(
  parameter int DEBOUNCE_MS   = 20,
  parameter int TIMEOUT_MS    = 999,
  parameter int DELAY_WDOG_MS = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       StartKey,
  input  logic       ReactKey,
  input  logic       myFLAG,
  output logic [1:0] state,
  output logic       TimedOut,
  output logic       FalseStart
);

  localparam int DEB_W     = $clog2(DEBOUNCE_MS + 1);
  localparam int PHASE_MAX = (TIMEOUT_MS > DELAY_WDOG_MS) ? TIMEOUT_MS : DELAY_WDOG_MS;
  localparam int PHASE_W   = $clog2(PHASE_MAX);

  localparam logic [DEB_W-1:0]   DEB_LAST     = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [PHASE_W-1:0] TIMEOUT_LAST = PHASE_W'(TIMEOUT_MS - 1);
  localparam logic [PHASE_W-1:0] WDOG_LAST    = PHASE_W'(DELAY_WDOG_MS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    TIMING  = 2'd2,
    DISPLAY = 2'd3
  } stateT;

  // Bit 0 is the start key, bit 1 the react key; both are active-low.
  logic [1:0]       rawKey;
  logic [1:0]       keySync1;
  logic [1:0]       keySync2;
  logic [1:0]       keyDeb;
  logic [1:0]       keyPulse;
  logic [DEB_W-1:0] debCnt [2];
  logic             startPulse;
  logic             reactPulse;

  assign rawKey     = {ReactKey, StartKey};
  assign startPulse = keyPulse[0];
  assign reactPulse = keyPulse[1];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      keySync1 <= 2'b11;
      keySync2 <= 2'b11;
      keyDeb   <= 2'b11;
      keyPulse <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        debCnt[k] <= '0;
      end
    end else begin
      keySync1 <= rawKey;
      keySync2 <= keySync1;
      for (int k = 0; k < 2; k++) begin
        keyPulse[k] <= 1'b0;
        if (keySync2[k] == keyDeb[k]) begin
          debCnt[k] <= '0;
        end else if (debCnt[k] == DEB_LAST) begin
          // Level has differed long enough: accept it, and flag a press on 1->0 only.
          keyDeb[k]   <= keySync2[k];
          debCnt[k]   <= '0;
          keyPulse[k] <= ~keySync2[k];
        end else begin
          debCnt[k] <= debCnt[k] + DEB_W'(1);
        end
      end
    end
  end

  stateT              curState;
  stateT              nextState;
  logic [PHASE_W-1:0] phaseCnt;
  logic               timedOutReg;
  logic               nextTimedOut;
  logic               clearFlags;
`ifdef REACTION_FALSE_START_EN
  logic               falseStartReg;
  logic               nextFalseStart;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      curState    <= IDLE;
      phaseCnt    <= '0;
      timedOutReg <= 1'b0;
`ifdef REACTION_FALSE_START_EN
      falseStartReg <= 1'b0;
`endif
    end else begin
      curState    <= nextState;
      timedOutReg <= nextTimedOut;
`ifdef REACTION_FALSE_START_EN
      falseStartReg <= nextFalseStart;
`endif
      // Only the two timed phases count; every state change restarts the count.
      if ((nextState != curState) || !(curState inside {DELAY, TIMING})) begin
        phaseCnt <= '0;
      end else begin
        phaseCnt <= phaseCnt + PHASE_W'(1);
      end
    end
  end

  always_comb begin
    nextState    = curState;
    nextTimedOut = timedOutReg;
    clearFlags   = 1'b0;
`ifdef REACTION_FALSE_START_EN
    nextFalseStart = falseStartReg;
`endif
    case (curState)
      IDLE: begin
        if (startPulse) begin
          nextState  = DELAY;
          clearFlags = 1'b1;
        end
      end
      DELAY: begin
`ifdef REACTION_FALSE_START_EN
        if (reactPulse) begin
          nextState      = DISPLAY;
          nextTimedOut   = 1'b0;
          nextFalseStart = 1'b1;
        end else
`endif
        if (myFLAG || (phaseCnt == WDOG_LAST)) begin
          nextState  = TIMING;
          clearFlags = 1'b1;
        end
      end
      TIMING: begin
        // A react press in the timeout cycle still counts as a real reaction.
        if (reactPulse) begin
          nextState    = DISPLAY;
          nextTimedOut = 1'b0;
        end else if (phaseCnt == TIMEOUT_LAST) begin
          nextState    = DISPLAY;
          nextTimedOut = 1'b1;
        end
      end
      DISPLAY: begin
        if (startPulse) begin
          nextState  = IDLE;
          clearFlags = 1'b1;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    if (clearFlags) begin
      nextTimedOut = 1'b0;
`ifdef REACTION_FALSE_START_EN
      nextFalseStart = 1'b0;
`endif
    end
  end

  assign state    = curState;
  assign TimedOut = timedOutReg;
`ifdef REACTION_FALSE_START_EN
  assign FalseStart = falseStartReg;
`else
  assign FalseStart = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: directed round scenarios plus random key/flag stimulus
// checked against a cycle-level reference model built from elapsed-time rules.
module tb_reaction_ctrl;

  localparam int DEB       = 20;
  localparam int TOUT      = 999;
  localparam int WDOG      = 2000;
  localparam int PRESS_LAT = DEB + 2;

  logic       Clock    = 1'b0;
  logic       Reset    = 1'b1;
  logic       StartKey = 1'b1;
  logic       ReactKey = 1'b1;
  logic       myFLAG   = 1'b0;
  logic [1:0] state;
  logic       TimedOut;
  logic       FalseStart;

  int total      = 0;
  int bad        = 0;
  int cycleNo    = 0;
  int delayEntry = 0;

  reaction_ctrl #(
    .DEBOUNCE_MS  (DEB),
    .TIMEOUT_MS   (TOUT),
    .DELAY_WDOG_MS(WDOG)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .StartKey  (StartKey),
    .ReactKey  (ReactKey),
    .myFLAG    (myFLAG),
    .state     (state),
    .TimedOut  (TimedOut),
    .FalseStart(FalseStart)
  );

  always #5 Clock = ~Clock;

  // Reference model: a key press is accepted once the synchronized level has
  // disagreed with the accepted level for DEB consecutive samples; phases end
  // when they have lasted their full length in cycles.
  int             mState      = 0;
  int             mNext       = 0;
  int             enterCycle  = 0;
  logic           mTimedOut   = 1'b0;
  logic           mFalseStart = 1'b0;
  logic [1:0]     mS1         = 2'b11;
  logic [1:0]     mS2         = 2'b11;
  logic [1:0]     mDeb        = 2'b11;
  logic [1:0]     mPulse      = 2'b00;
  logic           mSeen;
  logic [DEB-1:0] mHist [2];
  int             mHistLen [2];

  always @(posedge Clock) begin
    cycleNo = cycleNo + 1;
    if (Reset) begin
      mState      = 0;
      enterCycle  = cycleNo;
      mTimedOut   = 1'b0;
      mFalseStart = 1'b0;
      mS1         = 2'b11;
      mS2         = 2'b11;
      mDeb        = 2'b11;
      mPulse      = 2'b00;
      for (int k = 0; k < 2; k++) begin
        mHist[k]    = '0;
        mHistLen[k] = 0;
      end
    end else begin
      mNext = mState;
      case (mState)
        0: if (mPulse[0]) begin
          mNext = 1; mTimedOut = 1'b0; mFalseStart = 1'b0;
        end
        1: begin
`ifdef REACTION_FALSE_START_EN
          if (mPulse[1]) begin
            mNext = 3; mTimedOut = 1'b0; mFalseStart = 1'b1;
          end else
`endif
          if (myFLAG || (cycleNo - enterCycle) == WDOG) begin
            mNext = 2; mTimedOut = 1'b0; mFalseStart = 1'b0;
          end
        end
        2: if (mPulse[1]) begin
          mNext = 3; mTimedOut = 1'b0;
        end else if ((cycleNo - enterCycle) == TOUT) begin
          mNext = 3; mTimedOut = 1'b1;
        end
        3: if (mPulse[0]) begin
          mNext = 0; mTimedOut = 1'b0; mFalseStart = 1'b0;
        end
        default: mNext = 0;
      endcase
      if (mNext != mState) enterCycle = cycleNo;
      mState = mNext;
      for (int k = 0; k < 2; k++) begin
        mSeen     = mS2[k];
        mS2[k]    = mS1[k];
        mS1[k]    = (k == 0) ? StartKey : ReactKey;
        mPulse[k] = 1'b0;
        mHist[k]  = {mHist[k][DEB-2:0], mSeen};
        if (mHistLen[k] < DEB) mHistLen[k] = mHistLen[k] + 1;
        if (mHistLen[k] == DEB && mHist[k] == {DEB{~mDeb[k]}}) begin
          mDeb[k]     = ~mDeb[k];
          mHistLen[k] = 0;
          mPulse[k]   = ~mDeb[k];
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic tickUntil(input int target);
    while (cycleNo < target) tick();
  endtask

  task automatic enterDelay(output int entry);
    int c;
    StartKey = 1'b0;
    c = cycleNo;
    tickUntil(c + PRESS_LAT + 1);
    entry = cycleNo;
    StartKey = 1'b1;
    tickUntil(entry + 25);
  endtask

  task automatic backToIdle();
    int c;
    StartKey = 1'b0;
    c = cycleNo;
    tickUntil(c + PRESS_LAT + 1);
    StartKey = 1'b1;
    tickUntil(c + PRESS_LAT + 26);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) tick();
    total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    total++; if (TimedOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_timedout: got %0b want 0", TimedOut); end
    total++; if (FalseStart !== 1'b0) begin bad++; $display("[TB] FAIL reset_falsestart: got %0b want 0", FalseStart); end
    Reset = 1'b0;
    repeat (5) tick();
    total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL reset_idle_hold: got %0d want 0", state); end
  endtask

  task automatic test_start_bounce();
    int lowStart = 0;
    for (int i = 0; i < 15; i++) begin
      StartKey = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      if (i == 12) lowStart = cycleNo;
      tick();
      total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL bounce_early: got %0d want 0", state); end
    end
    tickUntil(lowStart + PRESS_LAT);
    total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL bounce_before_pulse: got %0d want 0", state); end
    tick();
    total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL bounce_to_delay: got %0d want 1", state); end
    delayEntry = cycleNo;
    StartKey = 1'b1;
    tickUntil(delayEntry + 40);
    total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL bounce_single_pulse: got %0d want 1", state); end
  endtask

  task automatic test_delay_flag();
    int eT;
    int c;
    tickUntil(delayEntry + 300);
    total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL flag_in_delay: got %0d want 1", state); end
    myFLAG = 1'b1;
    tick();
    myFLAG = 1'b0;
    eT = cycleNo;
    total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL flag_to_timing: got %0d want 2", state); end
    tickUntil(eT + 150);
    ReactKey = 1'b0;
    c = cycleNo;
    tickUntil(c + PRESS_LAT);
    total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL react_before_pulse: got %0d want 2", state); end
    tick();
    total++; if (state !== 2'd3) begin bad++; $display("[TB] FAIL react_to_display: got %0d want 3", state); end
    total++; if (TimedOut !== 1'b0) begin bad++; $display("[TB] FAIL react_timedout: got %0b want 0", TimedOut); end
    ReactKey = 1'b1;
    tickUntil(cycleNo + 25);
  endtask

  task automatic test_timeout();
    int eD;
    int eT;
    int c;
    backToIdle();
    total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL display_to_idle: got %0d want 0", state); end
    enterDelay(eD);
    myFLAG = 1'b1;
    tick();
    myFLAG = 1'b0;
    eT = cycleNo;
    tickUntil(eT + TOUT - 1);
    total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL timeout_early: got %0d want 2", state); end
    tick();
    total++; if (state !== 2'd3) begin bad++; $display("[TB] FAIL timeout_display: got %0d want 3", state); end
    total++; if (TimedOut !== 1'b1) begin bad++; $display("[TB] FAIL timeout_flag: got %0b want 1", TimedOut); end
    StartKey = 1'b0;
    c = cycleNo;
    tickUntil(c + PRESS_LAT);
    total++; if (TimedOut !== 1'b1) begin bad++; $display("[TB] FAIL timeout_held: got %0b want 1", TimedOut); end
    tick();
    total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL timeout_restart: got %0d want 0", state); end
    total++; if (TimedOut !== 1'b0) begin bad++; $display("[TB] FAIL timeout_cleared: got %0b want 0", TimedOut); end
    StartKey = 1'b1;
    tickUntil(cycleNo + 25);
  endtask

  task automatic test_watchdog();
    int eD;
    int eT;
    enterDelay(eD);
    tickUntil(eD + WDOG - 1);
    total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL wdog_early: got %0d want 1", state); end
    tick();
    total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL wdog_to_timing: got %0d want 2", state); end
    eT = cycleNo;
    tickUntil(eT + TOUT - 1 - PRESS_LAT);
    ReactKey = 1'b0;
    tickUntil(eT + TOUT - 1);
    total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL tie_early: got %0d want 2", state); end
    tick();
    total++; if (state !== 2'd3) begin bad++; $display("[TB] FAIL tie_display: got %0d want 3", state); end
    total++; if (TimedOut !== 1'b0) begin bad++; $display("[TB] FAIL tie_react_wins: got %0b want 0", TimedOut); end
    ReactKey = 1'b1;
    tickUntil(cycleNo + 25);
    backToIdle();
  endtask

  task automatic test_false_start();
    int eD;
    int c;
    enterDelay(eD);
    tickUntil(eD + 100);
    ReactKey = 1'b0;
    c = cycleNo;
    tickUntil(c + PRESS_LAT);
    total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL fs_before_pulse: got %0d want 1", state); end
    tick();
`ifdef REACTION_FALSE_START_EN
    total++; if (state !== 2'd3) begin bad++; $display("[TB] FAIL fs_state: got %0d want 3", state); end
    total++; if (FalseStart !== 1'b1) begin bad++; $display("[TB] FAIL fs_flag: got %0b want 1", FalseStart); end
    total++; if (TimedOut !== 1'b0) begin bad++; $display("[TB] FAIL fs_timedout: got %0b want 0", TimedOut); end
    ReactKey = 1'b1;
    tickUntil(c + 50);
`else
    total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL fs_state: got %0d want 1", state); end
    total++; if (FalseStart !== 1'b0) begin bad++; $display("[TB] FAIL fs_flag: got %0b want 0", FalseStart); end
    ReactKey = 1'b1;
    tickUntil(c + 50);
    myFLAG = 1'b1;
    tick();
    myFLAG = 1'b0;
    ReactKey = 1'b0;
    c = cycleNo;
    tickUntil(c + PRESS_LAT + 1);
    ReactKey = 1'b1;
    tickUntil(c + PRESS_LAT + 26);
`endif
    backToIdle();
    total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL fs_round_end: got %0d want 0", state); end
    total++; if (FalseStart !== 1'b0) begin bad++; $display("[TB] FAIL fs_cleared: got %0b want 0", FalseStart); end
  endtask

  task automatic test_reset_in_timing();
    int eD;
    enterDelay(eD);
    myFLAG = 1'b1;
    tick();
    myFLAG = 1'b0;
    total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL rst_mid_setup: got %0d want 2", state); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL rst_mid_state: got %0d want 0", state); end
    total++; if (TimedOut !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_timedout: got %0b want 0", TimedOut); end
  endtask

  task automatic test_random();
    int startHold = 0;
    int reactHold = 0;
    for (int i = 0; i < 6000; i++) begin
      if (startHold == 0) begin
        StartKey  = 1'($urandom_range(0, 1));
        startHold = $urandom_range(1, 50);
      end
      if (reactHold == 0) begin
        ReactKey  = 1'($urandom_range(0, 1));
        reactHold = $urandom_range(1, 50);
      end
      startHold--;
      reactHold--;
      myFLAG = ($urandom_range(0, 99) < 3);
      Reset  = ($urandom_range(0, 999) == 0);
      tick();
      total++; if (state !== 2'(mState)) begin bad++; $display("[TB] FAIL rand_state @%0d: got %0d want %0d", cycleNo, state, mState); end
      total++; if (TimedOut !== mTimedOut) begin bad++; $display("[TB] FAIL rand_timedout @%0d: got %0b want %0b", cycleNo, TimedOut, mTimedOut); end
      total++; if (FalseStart !== mFalseStart) begin bad++; $display("[TB] FAIL rand_falsestart @%0d: got %0b want %0b", cycleNo, FalseStart, mFalseStart); end
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_bounce();
    test_delay_flag();
    test_timeout();
    test_watchdog();
    test_false_start();
    test_reset_in_timing();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
